// File: rtl/fsmc_ctrl_pkg.sv
// Shared definitions for the FSMC control register bank: channel mode encoding
// and the register map offsets that sit above the per-channel shadow words.
package fsmc_ctrl_pkg;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_PULSE = 1'b1
    } chan_mode_t;

    function automatic int addr_mode(input int num_ch);
        return num_ch;
    endfunction

    function automatic int addr_commit(input int num_ch);
        return num_ch + 1;
    endfunction

endpackage

// File: rtl/fsmc_pulse_chan.sv
// One control channel: active word plus a down-counter that clears the word
// PULSE_LEN cycles after a load when the channel is in pulse mode.
module fsmc_pulse_chan
    import fsmc_ctrl_pkg::*;
#(
    parameter int DW        = 16,
    parameter int PULSE_LEN = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] value,
    input  chan_mode_t    mode,
    output logic [DW-1:0] active,
    output logic          busy
);

    localparam int            CW    = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] LEN_C = CW'(PULSE_LEN);

    logic [DW-1:0] act_d, act_q;
    logic [CW-1:0] cnt_d, cnt_q;

    // A load always wins over the running count, so a new commit restarts the
    // pulse and a level load stops any pulse in progress.
    always_comb begin
        act_d = act_q;
        cnt_d = cnt_q;
        if (load) begin
            act_d = value;
            cnt_d = (mode == MODE_PULSE) ? LEN_C : '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                act_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            act_q <= '0;
            cnt_q <= '0;
        end else begin
            act_q <= act_d;
            cnt_q <= cnt_d;
        end
    end

    assign active = act_q;
    assign busy   = (cnt_q != '0);

endmodule

// File: rtl/fsmc_ctrl_regbank.sv
// FSMC-side control register bank: shadow words and MODE written over the bus,
// transferred atomically to the channel outputs on a commit.
module fsmc_ctrl_regbank
    import fsmc_ctrl_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DW        = 16,
    parameter int AW        = 3,
    parameter int PULSE_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_valid,
    input  logic                 commit_i,
    output logic [NUM_CH*DW-1:0] ctrl_out,
    output logic                 ctrl_upd,
    output logic [NUM_CH-1:0]    pulse_busy,
    output logic                 addr_err
);

    localparam logic [AW-1:0] A_MODE   = AW'(addr_mode(NUM_CH));
    localparam logic [AW-1:0] A_COMMIT = AW'(addr_commit(NUM_CH));
    localparam int            N_MAPPED = NUM_CH + 2;

    logic [DW-1:0]     shadow_d [NUM_CH];
    logic [DW-1:0]     shadow_q [NUM_CH];
    logic [NUM_CH-1:0] mode_sh_d, mode_sh_q;
    logic [DW-1:0]     rd_data_d, rd_data_q;
    logic              rd_valid_d, rd_valid_q;
    logic              ctrl_upd_d, ctrl_upd_q;
    logic              addr_err_d, addr_err_q;

    logic wr_bad, rd_bad, commit;

    assign wr_bad = !(32'(wr_addr) < 32'(N_MAPPED));
    assign rd_bad = !(32'(rd_addr) < 32'(N_MAPPED));
    assign commit = commit_i | (wr_en & (wr_addr == A_COMMIT));

    // Channels load from shadow_q, so a write in the commit cycle only reaches
    // the shadow after the commit has taken the old contents.
    always_comb begin
        shadow_d  = shadow_q;
        mode_sh_d = mode_sh_q;
        if (wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == AW'(i)) begin
                    shadow_d[i] = wr_data;
                end
            end
            if (wr_addr == A_MODE) begin
                mode_sh_d = wr_data[NUM_CH-1:0];
            end
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            rd_data_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (rd_addr == AW'(i)) begin
                    rd_data_d = shadow_q[i];
                end
            end
            if (rd_addr == A_MODE) begin
                rd_data_d = DW'(mode_sh_q);
            end
        end
        ctrl_upd_d = commit;
        addr_err_d = (wr_en & wr_bad) | (rd_en & rd_bad);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q   <= '{default: '0};
            mode_sh_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ctrl_upd_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            mode_sh_q  <= mode_sh_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ctrl_upd_q <= ctrl_upd_d;
            addr_err_q <= addr_err_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fsmc_pulse_chan #(
            .DW        (DW),
            .PULSE_LEN (PULSE_LEN)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .load   (commit),
            .value  (shadow_q[g]),
            .mode   (chan_mode_t'(mode_sh_q[g])),
            .active (ctrl_out[g*DW +: DW]),
            .busy   (pulse_busy[g])
        );
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ctrl_upd = ctrl_upd_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_fsmc_ctrl_regbank.sv
// Directed bench for fsmc_ctrl_regbank with default parameters
// (4 channels, 16-bit words, 3-bit address, 8-cycle pulses).
module tb_fsmc_ctrl_regbank;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        commit_i;
    logic [63:0] ctrl_out;
    logic        ctrl_upd;
    logic [3:0]  pulse_busy;
    logic        addr_err;

    int total = 0;
    int bad   = 0;
    int c_a, c_b, c_busy, c_hold;
    logic [63:0] snap;

    fsmc_ctrl_regbank dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .commit_i   (commit_i),
        .ctrl_out   (ctrl_out),
        .ctrl_upd   (ctrl_upd),
        .pulse_busy (pulse_busy),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_rd(input logic [2:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_commit();
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
    endtask

    task automatic samp0();
        if (ctrl_out[15:0] == 16'h00FF) c_a++;
        if (ctrl_out[15:0] == 16'h0F0F) c_b++;
        if (pulse_busy[0]) c_busy++;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; commit_i = 1'b0;
        tick(); tick();
        rst = 1'b1;
        chk("rst_ctrl_out", ctrl_out, 64'h0);
        chk("rst_busy", pulse_busy, 4'h0);
        chk("rst_flags", {ctrl_upd, rd_valid, addr_err}, 3'b000);
        chk("rst_rd_data", rd_data, 16'h0);

        // LEVEL commit
        do_wr(3'd2, 16'hA5A5);
        chk("lvl_shadow_only", ctrl_out, 64'h0);
        do_wr(3'd5, 16'h0000);
        chk("lvl_ch2", ctrl_out[47:32], 16'hA5A5);
        chk("lvl_upd", ctrl_upd, 1'b1);
        tick();
        chk("lvl_upd_clear", ctrl_upd, 1'b0);
        c_hold = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ctrl_out[47:32] != 16'hA5A5) c_hold++;
        end
        chk("lvl_held_100", c_hold, 0);
        do_rd(3'd2);
        chk("rd_shadow2", {rd_valid, rd_data}, {1'b1, 16'hA5A5});
        tick();
        chk("rd_valid_pulse", {rd_valid, rd_data}, {1'b0, 16'hA5A5});

        // PULSE on ch0
        do_wr(3'd4, 16'h0001);
        do_wr(3'd0, 16'h00FF);
        c_a = 0; c_b = 0; c_busy = 0;
        do_wr(3'd5, 16'h1234);
        samp0();
        for (int i = 0; i < 19; i++) begin
            tick();
            samp0();
        end
        chk("pulse_len", c_a, 8);
        chk("pulse_busy_len", c_busy, 8);
        chk("pulse_end", {pulse_busy, ctrl_out[15:0]}, 20'h0);
        chk("pulse_ch2_kept", ctrl_out[47:32], 16'hA5A5);
        do_rd(3'd4);
        chk("rd_mode", rd_data, 16'h0001);

        // Restart during a pulse
        c_a = 0; c_b = 0; c_busy = 0;
        do_commit();
        samp0();
        for (int i = 0; i < 3; i++) begin
            tick();
            samp0();
        end
        do_wr(3'd0, 16'h0F0F);
        samp0();
        do_commit();
        samp0();
        for (int i = 0; i < 20; i++) begin
            tick();
            samp0();
        end
        chk("restart_first", c_a, 5);
        chk("restart_second", c_b, 8);
        chk("restart_busy", c_busy, 13);
        chk("restart_end", {pulse_busy, ctrl_out[15:0]}, 20'h0);

        // Write colliding with commit_i
        do_wr(3'd1, 16'h1111);
        do_commit();
        chk("col_setup", ctrl_out[31:16], 16'h1111);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1234; commit_i = 1'b1;
        tick();
        wr_en = 1'b0; commit_i = 1'b0;
        chk("col_old_value", ctrl_out[31:16], 16'h1111);
        chk("col_upd", ctrl_upd, 1'b1);
        do_rd(3'd1);
        chk("col_rd_new", {rd_valid, rd_data}, {1'b1, 16'h1234});
        rd_en = 1'b1; rd_addr = 3'd1;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h5678;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        chk("rw_same_addr", rd_data, 16'h1234);
        do_rd(3'd1);
        chk("rw_after", rd_data, 16'h5678);

        // PULSE -> LEVEL
        do_wr(3'd4, 16'h0000);
        do_wr(3'd5, 16'h0000);
        for (int i = 0; i < 20; i++) tick();
        chk("p2l_level", {pulse_busy, ctrl_out[15:0]}, {4'h0, 16'h0F0F});

        // Unmapped addresses
        snap = ctrl_out;
        do_wr(3'd7, 16'hFFFF);
        chk("bad_wr_err", addr_err, 1'b1);
        tick();
        chk("bad_wr_err_clr", addr_err, 1'b0);
        chk("bad_wr_nochg", ctrl_out, snap);
        do_rd(3'd2);
        chk("bad_wr_shadow", rd_data, 16'hA5A5);
        chk("good_rd_no_err", addr_err, 1'b0);
        do_rd(3'd7);
        chk("bad_rd", {addr_err, rd_valid, rd_data}, {1'b1, 1'b1, 16'h0});
        rd_en = 1'b1; rd_addr = 3'd6; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hAAAA;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        chk("bad_both_err", addr_err, 1'b1);
        tick();
        chk("bad_both_single", addr_err, 1'b0);
        do_rd(3'd5);
        chk("rd_commit_zero", {addr_err, rd_data, ctrl_upd}, {1'b0, 16'h0, 1'b0});
        chk("bad_nochg_end", ctrl_out, snap);

        // Reset in the middle of a pulse
        do_wr(3'd4, 16'h0008);
        do_wr(3'd3, 16'hBEEF);
        do_commit();
        chk("pre_rst_pulse", {pulse_busy[3], ctrl_out[63:48]}, {1'b1, 16'hBEEF});
        do_wr(3'd2, 16'h1111);
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h7777;
        rd_en = 1'b1; rd_addr = 3'd2;
        tick();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        chk("mid_rst_out", ctrl_out, 64'h0);
        chk("mid_rst_busy", pulse_busy, 4'h0);
        chk("mid_rst_flags", {ctrl_upd, rd_valid, addr_err, rd_data}, 19'h0);
        do_rd(3'd3);
        chk("mid_rst_shadow3", rd_data, 16'h0);
        do_rd(3'd4);
        chk("mid_rst_mode", rd_data, 16'h0);
        do_commit();
        chk("mid_rst_commit", {pulse_busy, ctrl_out}, 68'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
